wta_spike_encoder: RTL and testbench
====================================

Name: wta_spike_encoder

Overview:
Rate-coding front end for the winner-take-all core. It holds one 8-bit intensity per input channel and, during a fixed observation window, emits per-channel spike pulses. Each channel's spike rate is proportional to its intensity. It is the transmitter side of the spike interface the WTA core consumes; its outputs drive the core's spike inputs directly.

Parameters:
N_CH, 4, number of input channels / spike lines
W, 8, intensity and phase-accumulator width in bits
TICK_DIV, 4, clk cycles per spike tick (>=2)
WINDOW, 256, spike ticks per observation window (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
load_valid  input  1  intensity write request
load_ready  output  1  encoder can accept an intensity write
load_ch  input  clog2(N_CH)  channel index for the write
load_data  input  W  intensity value
start  input  1  begin an observation window
busy  output  1  window in progress
spikes  output  N_CH  per-channel spike bits, meaningful when spike_valid=1
spike_valid  output  1  one-cycle strobe marking a spike tick
done  output  1  one-cycle pulse on the final tick of a window

Behaviour:
- Single clock domain (clk); rst is synchronous, active-high.
- Reset: state=IDLE; all intensity regs, accumulators, prescaler and tick counter = 0; spikes=0, spike_valid=0, done=0, busy=0, load_ready=1.
- FSM IDLE -> RUN on start. RUN -> IDLE on the edge that processes tick WINDOW.
- busy=1 iff state==RUN; load_ready = !busy (combinational from state).
- Load: at an edge with load_valid & load_ready, intensity[load_ch] <= load_data. load_valid while busy is ignored and nothing changes. load_ch >= N_CH is ignored.
- start in IDLE:
  - on that edge, clear the accumulators, prescaler and tick counter, and enter RUN;
  - if load_valid is also asserted, the load is performed and the new value is used in this window;
  - start while RUN is ignored.
- Prescaler in RUN counts 0..TICK_DIV-1 and wraps. A tick occurs on each edge where prescaler==TICK_DIV-1.
- On a tick, for each channel: {c, acc} = acc + intensity (W+1-bit sum); acc <= low W bits; spikes[ch] <= c. spike_valid <= 1 and tick_cnt increments.
- On non-tick edges, spike_valid <= 0 and spikes <= 0. Outputs are registered.
- Latency: start sampled at edge E0 gives the first spike_valid high in the cycle after edge E0+TICK_DIV. Subsequent strobes come every TICK_DIV cycles.
- Window end: on the edge processing tick WINDOW, done <= 1 (same cycle as the last spike_valid) and state <= IDLE. done is low otherwise. A new start is accepted in the cycle after done.
- Per-window spike count for channel ch = floor(WINDOW*I/2^W) (accumulator starts at 0). Examples:
  - I=0: never spikes.
  - I=2^W-1: spikes on every tick except the first.
- Intensity regs persist across windows; only rst clears them.
- rst mid-window aborts immediately to the reset state. No done is issued.

Decomposition:
- Package wta_pkg: N_CH, W defaults; state enum {IDLE, RUN}; width helper constant CH_W=clog2(N_CH).
- Sub-module wta_rate_channel (one per channel, generate loop). It holds the intensity register and the accumulator, with ports clk, rst, ld_en, ld_data, clr, tick, spike.
- The top owns the FSM, prescaler, tick counter, handshake and output strobes.

Test Plan:
- Reset then idle: rst 2 cycles, no stimulus -> load_ready=1, busy=0, spike_valid/spikes/done stay 0 for 50 cycles.
- Rate coding (TICK_DIV=4, WINDOW=16): load ch0=128, ch1=64, ch2=255, ch3=0; start -> 16 spike_valid strobes, 4 cycles apart, first 4 cycles after the start edge. Counts: ch0=8 (first at tick 2), ch1=4 (first at tick 4), ch2=15 (all ticks except tick 1), ch3=0. done coincides with strobe 16.
- Load blocked while busy: during RUN, drive load_valid ch0=0 -> load_ready=0, ch0 count stays 8. After done, a second window repeats identical counts.
- Start/load collision and start ignored: start with load_valid ch1=192 in the same cycle -> ch1 count=12. Pulsing start again mid-window -> no restart, exactly 16 strobes.
- Reset mid-window: rst asserted after tick 5 -> next cycle busy=0, spike_valid=0, no done. Intensities read back as 0: a new start gives 0 spikes on all channels over 16 ticks.
- Back-to-back windows: start asserted in the cycle after done -> accepted, new window begins with accumulators cleared, identical spike pattern.

Source files
------------

// File: rtl/wta_pkg.sv
// Shared constants and types for the WTA spike encoder slice.
package wta_pkg;

  localparam int unsigned N_CH_DEF = 4;
  localparam int unsigned W_DEF    = 8;

  typedef enum logic {IDLE, RUN} state_e;

  // Index width that stays legal for a single-channel build.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CH_W = idx_width(N_CH_DEF);

endpackage

// File: rtl/wta_rate_channel.sv
// One rate-coded channel: intensity register plus phase accumulator whose carry is the spike.
module wta_rate_channel #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_en,
  input  logic [W-1:0] ld_data,
  input  logic         clr,
  input  logic         tick,
  output logic         spike
);

  logic [W-1:0] intensity;
  logic [W-1:0] acc;
  logic [W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, intensity};

  always_ff @(posedge clk) begin
    if (rst) begin
      intensity <= '0;
      acc       <= '0;
      spike     <= 1'b0;
    end else begin
      if (ld_en) intensity <= ld_data;
      if (clr) begin
        acc <= '0;
      end else if (tick) begin
        acc <= sum[W-1:0];
      end
      spike <= tick & sum[W];
    end
  end

endmodule

// File: rtl/wta_spike_encoder.sv
// Rate-coding spike source: per-channel phase accumulators stepped once per prescaled tick
// over a fixed window of WINDOW ticks.
module wta_spike_encoder
  import wta_pkg::*;
#(
  parameter int unsigned N_CH     = N_CH_DEF,
  parameter int unsigned W        = W_DEF,
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned WINDOW   = 256,
  localparam int unsigned LCH_W   = idx_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [LCH_W-1:0] load_ch,
  input  logic [W-1:0]     load_data,
  input  logic             start,
  output logic             busy,
  output logic [N_CH-1:0]  spikes,
  output logic             spike_valid,
  output logic             done
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned TW = $clog2(WINDOW + 1);

  state_e        state;
  logic [PW-1:0] presc;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          load_en;
  logic          clr;

  assign busy       = (state == RUN);
  assign load_ready = ~busy;
  assign load_en    = load_valid & load_ready;
  assign clr        = (state == IDLE) & start;
  assign tick       = (state == RUN) && (presc == PW'(TICK_DIV - 1));

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Out-of-range channel indices match no instance and are dropped.
    wta_rate_channel #(
      .W(W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .ld_en  (load_en && (load_ch == LCH_W'(i))),
      .ld_data(load_data),
      .clr    (clr),
      .tick   (tick),
      .spike  (spikes[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      presc       <= '0;
      tick_cnt    <= '0;
      spike_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      spike_valid <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            presc    <= '0;
            tick_cnt <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (tick) begin
            presc       <= '0;
            spike_valid <= 1'b1;
            tick_cnt    <= tick_cnt + TW'(1);
            if (tick_cnt == TW'(WINDOW - 1)) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wta_spike_encoder.sv
// Self-checking bench for wta_spike_encoder with an arithmetic rate-coding reference model.
module tb_wta_spike_encoder;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int TD   = 4;
  localparam int WIN  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [1:0] load_ch;
  logic [7:0] load_data;
  logic       start;
  logic       busy;
  logic [3:0] spikes;
  logic       spike_valid;
  logic       done;

  wta_spike_encoder #(
    .N_CH    (N_CH),
    .W       (W),
    .TICK_DIV(TD),
    .WINDOW  (WIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_ch    (load_ch),
    .load_data  (load_data),
    .start      (start),
    .busy       (busy),
    .spikes     (spikes),
    .spike_valid(spike_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int inten_m [N_CH];
  int spk_cnt [N_CH];
  int tick_vec[WIN];
  int n_strobe;
  int timing_err;
  int saw_done;

  typedef struct {
    int inten  [N_CH];
    int exp_cnt[N_CH];
  } vec_t;
  vec_t vecs[3];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Spike count of a window is floor(WIN*I/2^W).
  function automatic int model_count(input int i);
    return (WIN * i) / (1 << W);
  endfunction

  // A channel spikes at tick k when floor(k*I/2^W) steps up.
  function automatic int model_vec(input int k);
    int v = 0;
    for (int ch = 0; ch < N_CH; ch++)
      if ((k * inten_m[ch]) / (1 << W) > ((k - 1) * inten_m[ch]) / (1 << W)) v |= (1 << ch);
    return v;
  endfunction

  task automatic load(input int ch, input int data);
    @(negedge clk);
    load_valid = 1'b1;
    load_ch    = 2'(ch);
    load_data  = 8'(data);
    @(negedge clk);
    load_valid = 1'b0;
    inten_m[ch] = data;
  endtask

  task automatic do_start(input bit lv, input int ch, input int data);
    @(negedge clk);
    start      = 1'b1;
    load_valid = lv;
    load_ch    = 2'(ch);
    load_data  = 8'(data);
    @(negedge clk);
    start      = 1'b0;
    load_valid = 1'b0;
    if (lv) inten_m[ch] = data;
    check("busy_after_start", int'(busy), 1);
  endtask

  // action 1: attempt a load of ch0=0 mid-window; action 2: pulse start mid-window.
  task automatic collect(input int action);
    for (int ch = 0; ch < N_CH; ch++) spk_cnt[ch] = 0;
    for (int k = 0; k < WIN; k++) tick_vec[k] = -1;
    n_strobe   = 0;
    timing_err = 0;
    saw_done   = 0;
    for (int c = 1; c <= WIN * TD + 20; c++) begin
      @(negedge clk);
      if (action == 1 && c == 6) begin
        check("load_ready_busy", int'(load_ready), 0);
        load_valid = 1'b1;
        load_ch    = 2'd0;
        load_data  = 8'd0;
      end
      if (action == 1 && c == 7) load_valid = 1'b0;
      if (action == 2 && c == 10) start = 1'b1;
      if (action == 2 && c == 11) start = 1'b0;
      if (spike_valid) begin
        n_strobe++;
        if (c != TD * n_strobe) timing_err++;
        if (n_strobe <= WIN) tick_vec[n_strobe-1] = int'(spikes);
        for (int ch = 0; ch < N_CH; ch++) spk_cnt[ch] += int'(spikes[ch]);
      end else if (spikes != 4'd0) begin
        timing_err++;
      end
      if (done) begin
        saw_done = 1;
        if (!spike_valid || n_strobe != WIN) timing_err++;
        break;
      end
    end
    load_valid = 1'b0;
    start      = 1'b0;
    check("window_done_seen", saw_done, 1);
  endtask

  task automatic check_window();
    check("strobe_count", n_strobe, WIN);
    check("strobe_timing", timing_err, 0);
    for (int ch = 0; ch < N_CH; ch++) check("model_count", spk_cnt[ch], model_count(inten_m[ch]));
    for (int k = 0; k < WIN; k++) check("tick_pattern", tick_vec[k], model_vec(k + 1));
  endtask

  initial begin
    int errs;
    int cnt;
    vecs[0].inten = '{128, 64, 255, 0};   vecs[0].exp_cnt = '{8, 4, 15, 0};
    vecs[1].inten = '{1, 16, 17, 200};    vecs[1].exp_cnt = '{0, 1, 1, 12};
    vecs[2].inten = '{240, 32, 100, 192}; vecs[2].exp_cnt = '{15, 2, 6, 12};
    for (int ch = 0; ch < N_CH; ch++) inten_m[ch] = 0;

    rst        = 1'b1;
    load_valid = 1'b0;
    load_ch    = 2'd0;
    load_data  = 8'd0;
    start      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_load_ready", int'(load_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_spike_valid", int'(spike_valid), 0);
    check("rst_spikes", int'(spikes), 0);
    check("rst_done", int'(done), 0);

    errs = 0;
    repeat (50) begin
      @(negedge clk);
      if (spike_valid || done || busy || spikes != 4'd0 || !load_ready) errs++;
    end
    check("idle_quiet", errs, 0);

    for (int v = 0; v < 3; v++) begin
      for (int ch = 0; ch < N_CH; ch++) load(ch, vecs[v].inten[ch]);
      do_start(1'b0, 0, 0);
      collect(0);
      check_window();
      for (int ch = 0; ch < N_CH; ch++) check("table_count", spk_cnt[ch], vecs[v].exp_cnt[ch]);
      if (v == 0) begin
        check("tick1_pattern", tick_vec[0], 0);
        check("tick2_pattern", tick_vec[1], 5);
      end
    end

    // Load blocked while busy, then a back-to-back window with the same intensities.
    load(0, 128); load(1, 64); load(2, 255); load(3, 0);
    do_start(1'b0, 0, 0);
    collect(1);
    check_window();
    check("blocked_load_ch0", spk_cnt[0], 8);
    do_start(1'b0, 0, 0);
    collect(0);
    check_window();
    check("b2b_ch0", spk_cnt[0], 8);
    check("b2b_ch2", spk_cnt[2], 15);

    // Start with simultaneous load, plus a start pulse mid-window.
    do_start(1'b1, 1, 192);
    collect(2);
    check_window();
    check("collision_ch1", spk_cnt[1], 12);

    repeat (5) begin
      for (int ch = 0; ch < N_CH; ch++) load(ch, int'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) do_start(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      else do_start(1'b0, 0, 0);
      collect(0);
      check_window();
    end

    // Reset mid-window after tick 5.
    load(0, 200); load(1, 100); load(2, 255); load(3, 50);
    do_start(1'b0, 0, 0);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (spike_valid) cnt++;
      if (cnt == 5) break;
    end
    check("reached_tick5", cnt, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_spike_valid", int'(spike_valid), 0);
    check("abort_done", int'(done), 0);
    check("abort_load_ready", int'(load_ready), 1);
    for (int ch = 0; ch < N_CH; ch++) inten_m[ch] = 0;
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || spike_valid) errs++;
    end
    check("abort_quiet", errs, 0);
    do_start(1'b0, 0, 0);
    collect(0);
    check_window();
    for (int ch = 0; ch < N_CH; ch++) check("post_rst_zero", spk_cnt[ch], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
